// File: rtl/weight_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl_pkg
// Shared definitions for the conv-block weight fetch sequencer:
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - default kernel geometry for one conv block
//   - counter/index width helpers
// -----------------------------------------------------------------------------
package weight_fetch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    // 7 taps x 8 channels of binary weights, packed into two 32-bit ROM words
    localparam int WFC_DEF_KERNEL_BITS = 56;
    localparam int WFC_DEF_NUM_WORDS   = 2;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index that addresses n slots (0..n-1), never less than 1.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_fetch_ctrl_word_assembler.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl_word_assembler
// Packs ROM words into the weight assembly register. Word k lands in bits
// [k*DATA_WIDTH +: DATA_WIDTH]; bits at or above KERNEL_BITS are never stored.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous discard of the partial assembly
//   cap_en       capture strobe: cap_data is written into slot cap_idx
//   cap_idx      word slot being captured
//   cap_data     ROM read data
//   asm_vec      assembly contents including the word captured this cycle,
//                so the owner can load the complete vector on the last capture
// -----------------------------------------------------------------------------
module weight_fetch_ctrl_word_assembler
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WORDS   = WFC_DEF_NUM_WORDS,
    parameter int KERNEL_BITS = WFC_DEF_KERNEL_BITS,
    parameter int IDX_W       = idx_width(NUM_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   cap_en,
    input  logic [IDX_W-1:0]       cap_idx,
    input  logic [DATA_WIDTH-1:0]  cap_data,
    output logic [KERNEL_BITS-1:0] asm_vec
);

    logic [KERNEL_BITS-1:0] asm_q;

    // Bitwise merge so the discarded upper part of the last word never exists.
    always_comb begin
        asm_vec = asm_q;
        if (cap_en) begin
            for (int b = 0; b < KERNEL_BITS; b++) begin
                if (cap_idx == IDX_W'(b / DATA_WIDTH)) begin
                    asm_vec[b] = cap_data[b % DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
        end else if (clear) begin
            asm_q <= '0;
        end else if (cap_en) begin
            asm_q <= asm_vec;
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl
// Fetches one conv block's binary kernel weights from a 1-cycle-latency
// synchronous ROM, assembles them into a KERNEL_BITS-wide vector and hands the
// vector to the PE array over valid/ready. All outputs are registered.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        single-cycle fetch request (ignored unless idle)
//   clear        synchronous abort to IDLE, highest priority
//   rom_en       ROM read enable
//   rom_addr     ROM read address (holds when rom_en is low)
//   rom_data     ROM read data, valid the cycle after rom_en
//   w_vec        assembled weight vector (holds until the next load)
//   w_valid      w_vec valid
//   w_ready      PE array accepts w_vec
//   busy         block not idle
//   done         one-cycle pulse after the handshake completes
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | one ROM read issued per cycle, NUM_WORDS reads in total
// DRAIN | reads all issued; waiting for the final word to be captured
// VALID | w_vec presented, waiting for w_ready
// -----------------------------------------------------------------------------
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WORDS   = WFC_DEF_NUM_WORDS,
    parameter int KERNEL_BITS = WFC_DEF_KERNEL_BITS,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic [KERNEL_BITS-1:0] w_vec,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = cnt_width(NUM_WORDS);
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CNT_W-1:0]      LAST_ISS = CNT_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]      LAST_CAP = IDX_W'(NUM_WORDS - 1);

    if (KERNEL_BITS > NUM_WORDS * DATA_WIDTH) begin : g_bad_kernel_bits
        $error("weight_fetch_ctrl: KERNEL_BITS exceeds NUM_WORDS*DATA_WIDTH");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_num_words
        $error("weight_fetch_ctrl: NUM_WORDS out of range");
    end

    logic [1:0]             state;
    logic [CNT_W-1:0]       issue_cnt;
    logic [IDX_W-1:0]       cap_cnt;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    // High in the cycle where rom_data carries the word requested by rom_en
    // in the previous cycle.
    logic                   rd_pend;
    logic [KERNEL_BITS-1:0] asm_vec;
    logic                   last_cap;

    assign last_cap = rd_pend && (cap_cnt == LAST_CAP);

    weight_fetch_ctrl_word_assembler #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_WORDS   (NUM_WORDS),
        .KERNEL_BITS (KERNEL_BITS),
        .IDX_W       (IDX_W)
    ) u_word_assembler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .cap_en   (rd_pend),
        .cap_idx  (cap_cnt),
        .cap_data (rom_data),
        .asm_vec  (asm_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            fetch_addr <= '0;
            rd_pend    <= 1'b0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            w_vec      <= '0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clear) begin
            // In-flight reads are dropped by clearing rd_pend; w_vec and
            // rom_addr keep their values.
            state     <= ST_IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            rd_pend   <= 1'b0;
            rom_en    <= 1'b0;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_pend <= rom_en;

            if (rd_pend) begin
                cap_cnt <= last_cap ? '0 : cap_cnt + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    rom_en <= 1'b0;
                    if (start) begin
                        state      <= ST_FETCH;
                        busy       <= 1'b1;
                        issue_cnt  <= '0;
                        cap_cnt    <= '0;
                        fetch_addr <= BASE;
                    end
                end
                ST_FETCH: begin
                    rom_en     <= 1'b1;
                    rom_addr   <= fetch_addr;
                    fetch_addr <= fetch_addr + 1'b1;
                    issue_cnt  <= issue_cnt + 1'b1;
                    if (issue_cnt == LAST_ISS) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    rom_en <= 1'b0;
                    if (last_cap) begin
                        state   <= ST_VALID;
                        w_vec   <= asm_vec;
                        w_valid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    rom_en <= 1'b0;
                    if (w_ready) begin
                        state   <= ST_IDLE;
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rom_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_fetch_ctrl
// Two instances share all control inputs: u_dut with BASE_ADDR=0 and u_wrap
// with BASE_ADDR=255 (address wraps 255 -> 0). Each has its own ROM model.
// -----------------------------------------------------------------------------
module tb_weight_fetch_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int KB = 56;

    localparam logic [KB-1:0] V1 = 56'hC33C96A5A55A5A;
    localparam logic [KB-1:0] W1 = 56'hA55A5A12345678;
    localparam logic [KB-1:0] V2 = 56'h66778811223344;
    localparam logic [KB-1:0] W2 = 56'h22334412345678;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic w_ready = 1'b0;

    logic          rom_en, rom_en_w;
    logic [AW-1:0] rom_addr, rom_addr_w;
    logic [DW-1:0] rom_data, rom_data_w;
    logic [KB-1:0] w_vec, w_vec_w;
    logic          w_valid, w_valid_w;
    logic          busy, busy_w;
    logic          done, done_w;

    logic [DW-1:0] rom [0:255];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    weight_fetch_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .w_vec(w_vec), .w_valid(w_valid), .w_ready(w_ready),
        .busy(busy), .done(done)
    );

    weight_fetch_ctrl #(.BASE_ADDR(255)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .rom_en(rom_en_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .w_vec(w_vec_w), .w_valid(w_valid_w), .w_ready(w_ready),
        .busy(busy_w), .done(done_w)
    );

    always @(posedge clk) begin
        if (rom_en)   rom_data   <= rom[rom_addr];
        if (rom_en_w) rom_data_w <= rom[rom_addr_w];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic          start, clear, ready;
        logic          en, valid, busy, done;
        logic [AW-1:0] addr, addr_w;
        logic [KB-1:0] vec, vec_w;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input logic s, c, r, en, input logic [AW-1:0] a, aw,
                                input logic v, b, d, input logic [KB-1:0] vec, vw);
        row_t t;
        t.start = s; t.clear = c; t.ready = r;
        t.en = en; t.addr = a; t.addr_w = aw;
        t.valid = v; t.busy = b; t.done = d;
        t.vec = vec; t.vec_w = vw;
        return t;
    endfunction

    // Start pulse, wait (bounded) for w_valid, check latency, vectors, done.
    task automatic run_fetch(input logic [KB-1:0] ev, ew, input string tag);
        int lat = 0;
        int en_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!w_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (rom_en) en_cnt++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_rom_en_cycles"}, 64'(en_cnt), 64'd2);
        chk({tag, "_w_vec"}, 64'(w_vec), 64'(ev));
        chk({tag, "_wrap_w_vec"}, 64'(w_vec_w), 64'(ew));
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_valid_drop"}, 64'(w_valid), 64'd0);
        @(negedge clk);
        w_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        rom[0]   = 32'hA5A55A5A;
        rom[1]   = 32'h00C33C96;
        rom[255] = 32'h12345678;

        // Reset state
        #3;
        chk("rst_rom_en",   64'(rom_en),   64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_w_vec",    64'(w_vec),    64'd0);
        chk("rst_w_valid",  64'(w_valid),  64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // s  c  r  en addr aw  v  b  d  vec vec_w
        // Normal fetch, w_ready already high
        rows.push_back(mk(1,0,1, 0,8'd0,8'd0,   0,1,0, '0,'0));
        rows.push_back(mk(0,0,1, 1,8'd0,8'd255, 0,1,0, '0,'0));
        rows.push_back(mk(0,0,1, 1,8'd1,8'd0,   0,1,0, '0,'0));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   0,1,0, '0,'0));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   1,1,0, V1,W1));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   0,0,1, V1,W1));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   0,0,0, V1,W1));
        // Backpressure: w_ready low for 5 VALID cycles
        rows.push_back(mk(1,0,0, 0,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 1,8'd0,8'd255, 0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 1,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   0,1,0, V1,W1));
        for (int i = 0; i < 5; i++)
            rows.push_back(mk(0,0,0, 0,8'd1,8'd0, 1,1,0, V1,W1));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   0,0,1, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   0,0,0, V1,W1));
        // start re-pulsed during FETCH and VALID
        rows.push_back(mk(1,0,0, 0,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(1,0,0, 1,8'd0,8'd255, 0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 1,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   1,1,0, V1,W1));
        rows.push_back(mk(1,0,0, 0,8'd1,8'd0,   1,1,0, V1,W1));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   0,0,1, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   0,0,0, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   0,0,0, V1,W1));
        // clear while VALID beats a simultaneous w_ready
        rows.push_back(mk(1,0,0, 0,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 1,8'd0,8'd255, 0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 1,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   0,1,0, V1,W1));
        rows.push_back(mk(0,0,0, 0,8'd1,8'd0,   1,1,0, V1,W1));
        rows.push_back(mk(0,1,1, 0,8'd1,8'd0,   0,0,0, V1,W1));
        rows.push_back(mk(0,0,1, 0,8'd1,8'd0,   0,0,0, V1,W1));

        foreach (rows[i]) begin
            @(negedge clk);
            start   = rows[i].start;
            clear   = rows[i].clear;
            w_ready = rows[i].ready;
            @(posedge clk); #1;
            chk($sformatf("row%0d_rom_en", i),     64'(rom_en),     64'(rows[i].en));
            chk($sformatf("row%0d_rom_addr", i),   64'(rom_addr),   64'(rows[i].addr));
            chk($sformatf("row%0d_wrap_addr", i),  64'(rom_addr_w), 64'(rows[i].addr_w));
            chk($sformatf("row%0d_w_valid", i),    64'(w_valid),    64'(rows[i].valid));
            chk($sformatf("row%0d_busy", i),       64'(busy),       64'(rows[i].busy));
            chk($sformatf("row%0d_done", i),       64'(done),       64'(rows[i].done));
            chk($sformatf("row%0d_w_vec", i),      64'(w_vec),      64'(rows[i].vec));
            chk($sformatf("row%0d_wrap_w_vec", i), 64'(w_vec_w),    64'(rows[i].vec_w));
        end
        @(negedge clk);
        start = 1'b0; clear = 1'b0; w_ready = 1'b0;

        // clear in the cycle after the first rom_en
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("clr_first_rom_en", 64'(rom_en), 64'd1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_busy",     64'(busy),     64'd0);
        chk("clr_rom_en",   64'(rom_en),   64'd0);
        chk("clr_rom_addr", 64'(rom_addr), 64'd0);
        acc = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rom_en || w_valid || done || busy) acc++;
        end
        chk("clr_quiet_cycles", 64'(acc), 64'd0);
        chk("clr_w_vec_kept",   64'(w_vec), 64'(V1));
        rom[0] = 32'h11223344;
        rom[1] = 32'h55667788;
        run_fetch(V2, W2, "after_clear");

        // Asynchronous reset mid-DRAIN
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_busy_before_rst", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rom_en",   64'(rom_en),   64'd0);
        chk("arst_rom_addr", 64'(rom_addr), 64'd0);
        chk("arst_w_vec",    64'(w_vec),    64'd0);
        chk("arst_w_valid",  64'(w_valid),  64'd0);
        chk("arst_busy",     64'(busy),     64'd0);
        chk("arst_done",     64'(done),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_no_late_valid", 64'(w_valid), 64'd0);
        run_fetch(V2, W2, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
